// File: rtl/fp_addsub_param_if.sv
// Operand/result bus for fp_addsub_param: one valid/ready transfer carries both
// operands and the op; the result side is an independent valid/ready channel.
interface fp_addsub_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_z, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_z, out_flags
  );
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised IEEE-754 add/subtract with round-to-nearest-even
// and {invalid, overflow, underflow, inexact} flags.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_addsub_param_if.slave bus,
  output logic             busy,
  output logic [3:0]       o_dbg_state
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_OUT
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a, r_b, r_z;
  logic           r_sa, r_sb, r_s;
  logic [EW-1:0]  r_ea, r_eb, r_e;
  logic [M-1:0]   r_ma, r_mb, r_m;
  logic [MAN_W:0] r_man;
  logic           r_inexact;
  logic [3:0]     r_flags;
  logic           r_in_ready, r_out_valid, r_busy;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and payload is held while valid.
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_z;
  assign bus.out_flags = r_flags;
  assign busy          = r_busy;
  assign o_dbg_state   = r_state;

  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_exp) && (|w_a_frac);
  assign w_b_nan  = (&w_b_exp) && (|w_b_frac);
  assign w_a_snan = w_a_nan && !w_a_frac[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_b_frac[MAN_W-1];
  assign w_a_inf  = (&w_a_exp) && !(|w_a_frac);
  assign w_b_inf  = (&w_b_exp) && !(|w_b_frac);
  assign w_a_zero = !(|w_a_exp) && !(|w_a_frac);
  assign w_b_zero = !(|w_b_exp) && !(|w_b_frac);

  logic [EW-1:0] w_diff;
  logic          w_diff_big;
  assign w_diff     = r_ea - r_eb;
  assign w_diff_big = ({{(32-EW){1'b0}}, w_diff} > 32'(MAN_W + 3));

  // Operand A holds the larger exponent after SPECIAL, so only mantissas decide
  // which magnitude is larger once aligned.
  logic [M:0] w_sum;
  logic       w_sum_sign;
  always_comb begin
    w_sum      = '0;
    w_sum_sign = r_sa;
    if (r_sa == r_sb) begin
      w_sum = {1'b0, r_ma} + {1'b0, r_mb};
    end else if (r_ma >= r_mb) begin
      w_sum = {1'b0, r_ma} - {1'b0, r_mb};
    end else begin
      w_sum      = {1'b0, r_mb} - {1'b0, r_ma};
      w_sum_sign = r_sb;
    end
  end

  logic           w_inc;
  logic [MAN_W+1:0] w_mant_r;
  assign w_inc    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_mant_r = {1'b0, r_m[M-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_z         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_s         <= 1'b0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_e         <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_m         <= '0;
      r_man       <= '0;
      r_inexact   <= 1'b0;
      r_flags     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.in_a;
            r_b        <= {bus.in_b[W-1] ^ bus.in_op, bus.in_b[W-2:0]};
            r_flags    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sa    <= r_a[W-1];
          r_sb    <= r_b[W-1];
          r_ea    <= (|w_a_exp) ? {2'b00, w_a_exp} : E_ONE;
          r_eb    <= (|w_b_exp) ? {2'b00, w_b_exp} : E_ONE;
          r_ma    <= {|w_a_exp, w_a_frac, 3'b000};
          r_mb    <= {|w_b_exp, w_b_frac, 3'b000};
          r_state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          r_state     <= S_OUT;
          r_out_valid <= 1'b1;
          if (w_a_nan || w_b_nan) begin
            r_z     <= QNAN;
            r_flags <= {w_a_snan | w_b_snan, 3'b000};
          end else if (w_a_inf && w_b_inf && (r_sa != r_sb)) begin
            r_z     <= QNAN;
            r_flags <= 4'b1000;
          end else if (w_a_inf) begin
            r_z <= r_a;
          end else if (w_b_inf) begin
            r_z <= r_b;
          end else if (w_a_zero && w_b_zero) begin
            r_z <= {r_sa & r_sb, {(W-1){1'b0}}};
          end else if (w_a_zero) begin
            r_z <= r_b;
          end else if (w_b_zero) begin
            r_z <= r_a;
          end else begin
            r_state     <= S_ALIGN;
            r_out_valid <= 1'b0;
            if (r_ea < r_eb) begin
              r_sa <= r_sb;  r_sb <= r_sa;
              r_ea <= r_eb;  r_eb <= r_ea;
              r_ma <= r_mb;  r_mb <= r_ma;
            end
          end
        end
        S_ALIGN: begin
          if (w_diff == '0) begin
            r_state <= S_ADD;
          end else if (w_diff_big) begin
            r_mb <= {{(M-1){1'b0}}, |r_mb};
            r_eb <= r_ea;
          end else begin
            r_mb <= {1'b0, r_mb[M-1:2], r_mb[1] | r_mb[0]};
            r_eb <= r_eb + E_ONE;
          end
        end
        S_ADD: begin
          r_s <= w_sum_sign;
          if (w_sum == '0) begin
            r_z         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (w_sum[M]) begin
            r_m     <= {w_sum[M:2], w_sum[1] | w_sum[0]};
            r_e     <= r_ea + E_ONE;
            r_state <= S_NORM;
          end else begin
            r_m     <= w_sum[M-1:0];
            r_e     <= r_ea;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (!r_m[M-1] && (r_e > E_ONE)) begin
            r_m <= {r_m[M-2:0], 1'b0};
            r_e <= r_e - E_ONE;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_inexact <= r_m[2] | r_m[1] | r_m[0];
          // A carry out of the rounded mantissa renormalises; a subnormal that
          // rounds up simply gains its hidden bit at exponent 1.
          if (w_mant_r[MAN_W+1]) begin
            r_man <= w_mant_r[MAN_W+1:1];
            r_e   <= r_e + E_ONE;
          end else begin
            r_man <= w_mant_r[MAN_W:0];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_e >= E_MAX) begin
            r_z     <= {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_flags <= 4'b0101;
          end else begin
            r_z     <= {r_s, r_man[MAN_W] ? r_e[EXP_W-1:0] : {EXP_W{1'b0}}, r_man[MAN_W-1:0]};
            r_flags <= {2'b00, !r_man[MAN_W] && r_inexact, r_inexact};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
